// File: rtl/sequence_generator.sv
// Serial pattern generator: emits a latched bit pattern MSB first, repeated a
// programmable number of times with optional idle gaps, then pulses done.
// Every output comes straight from a flop; next-output values are derived
// from next-state values so the first pattern bit appears one cycle after start.
module sequence_generator #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       repeat_cnt,
    input  logic             abort,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(WIDTH - 1);
    // Gap counter loads GAP_CYCLES-1 and counts down to 0 inclusive.
    localparam logic [3:0] GapLast = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [3:0]       reps_q, reps_d;   // repetitions left, including the current one
    logic [3:0]       gap_q, gap_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, counter and next-output logic.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        gap_d   = gap_q;

        unique case (state_q)
            StIdle: begin
                // start beats abort here; abort is meaningless in idle anyway.
                if (start) begin
                    state_d = StSend;
                    pat_d   = pattern;
                    reps_d  = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
                    idx_d   = IdxTop;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                    pat_d   = '0;
                    idx_d   = '0;
                    reps_d  = '0;
                    gap_d   = '0;
                end else if (idx_q == '0) begin
                    if (reps_q > 4'd1) begin
                        reps_d = reps_q - 4'd1;
                        idx_d  = IdxTop;
                        if (GAP_CYCLES > 0) begin
                            state_d = StGap;
                            gap_d   = GapLast;
                        end
                    end else begin
                        state_d = StDone;
                        reps_d  = '0;
                    end
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                    pat_d   = '0;
                    idx_d   = '0;
                    reps_d  = '0;
                    gap_d   = '0;
                end else if (gap_q == 4'd0) begin
                    state_d = StSend;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            StDone: begin
                // start is deliberately not looked at here.
                state_d = StIdle;
                pat_d   = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        out_d   = (state_d == StSend) && pat_d[idx_d];
        valid_d = (state_d == StSend);
        busy_d  = (state_d == StSend) || (state_d == StGap);
        done_d  = (state_d == StDone);
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pat_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: one instance with a 2-cycle gap (a)
// and one with no gap (b), sharing all inputs, each feeding a 1011 detector.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic [3:0] repeat_cnt = 4'd0;
    logic       abort = 1'b0;

    logic out_a, valid_a, busy_a, done_a;
    logic out_b, valid_b, busy_b, done_b;

    int n_chk = 0;
    int n_err = 0;

    // Overlapping 1011 detectors on each serial output.
    logic [3:0] sh_a = 4'd0;
    logic [3:0] sh_b = 4'd0;
    int det_a = 0;
    int det_b = 0;

    always #5 clk = ~clk;

    sequence_generator #(.WIDTH(4), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .abort(abort),
        .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a)
    );

    sequence_generator #(.WIDTH(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .abort(abort),
        .out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b)
    );

    // Detector shift registers, clocked like a downstream block would be.
    always @(posedge clk) begin
        sh_a <= {sh_a[2:0], out_a};
        sh_b <= {sh_b[2:0], out_b};
        if ({sh_a[2:0], out_a} == 4'b1011) det_a <= det_a + 1;
        if ({sh_b[2:0], out_b} == 4'b1011) det_b <= det_b + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input bit inst, input logic eo, input logic ev,
                       input logic eb, input logic ed);
        logic o, v, b, d;
        if (inst) begin
            o = out_b; v = valid_b; b = busy_b; d = done_b;
        end else begin
            o = out_a; v = valid_a; b = busy_a; d = done_a;
        end
        chk({tag, "_out"},   {31'd0, o}, {31'd0, eo});
        chk({tag, "_valid"}, {31'd0, v}, {31'd0, ev});
        chk({tag, "_busy"},  {31'd0, b}, {31'd0, eb});
        chk({tag, "_done"},  {31'd0, d}, {31'd0, ed});
    endtask

    // Caller raises start; this takes the accepting edge and checks the whole
    // transmission, the done pulse, the following idle cycle and busy length.
    task automatic expect_tx(input string tag, input bit inst, input logic [3:0] pat,
                             input int r, input int g);
        int busy_n;
        busy_n = 0;
        step();
        start = 1'b0;
        for (int rep = 0; rep < r; rep++) begin
            for (int bi = 3; bi >= 0; bi--) begin
                cyc(tag, inst, pat[bi], 1'b1, 1'b1, 1'b0);
                busy_n += int'(inst ? busy_b : busy_a);
                step();
            end
            if (rep < r - 1) begin
                for (int k = 0; k < g; k++) begin
                    cyc({tag, "_gap"}, inst, 1'b0, 1'b0, 1'b1, 1'b0);
                    busy_n += int'(inst ? busy_b : busy_a);
                    step();
                end
            end
        end
        cyc({tag, "_donecyc"}, inst, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        cyc({tag, "_after"}, inst, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_busytotal"}, busy_n, r * 4 + (r - 1) * g);
    endtask

    initial begin
        int d0;

        // Reset state, with start asserted to show reset priority.
        start = 1'b1;
        pattern = 4'b1011;
        step();
        step();
        cyc("reset_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset_b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        start = 1'b0;
        step();
        cyc("idle_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single repetition 1011.
        d0 = det_a;
        pattern = 4'b1011; repeat_cnt = 4'd1; start = 1'b1;
        expect_tx("rep1", 1'b0, 4'b1011, 1, 2);
        chk("rep1_detect", det_a - d0, 1);

        // Two repetitions with a 2-cycle gap.
        d0 = det_a;
        pattern = 4'b1011; repeat_cnt = 4'd2; start = 1'b1;
        expect_tx("rep2", 1'b0, 4'b1011, 2, 2);
        chk("rep2_detect", det_a - d0, 2);

        // repeat_cnt 0 behaves as 1.
        pattern = 4'b1011; repeat_cnt = 4'd0; start = 1'b1;
        expect_tx("rep0", 1'b0, 4'b1011, 1, 2);

        // Three back-to-back repetitions on the gapless instance.
        d0 = det_b;
        pattern = 4'b1011; repeat_cnt = 4'd3; start = 1'b1;
        expect_tx("rep3_gap0", 1'b1, 4'b1011, 3, 0);
        chk("rep3_detect", det_b - d0, 3);
        repeat (6) step();
        cyc("rep3_a_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // start re-pulsed and inputs changed mid-stream; start held into DONE.
        pattern = 4'b1011; repeat_cnt = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        cyc("ign_b3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        pattern = 4'b0110; repeat_cnt = 4'd3; start = 1'b1;
        step();
        cyc("ign_b2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        cyc("ign_b1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        cyc("ign_b0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        cyc("ign_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        cyc("ign_nostart_in_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        step();
        cyc("ign_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort during bit 2.
        pattern = 4'b1011; repeat_cnt = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        cyc("abort_b3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        cyc("abort_b2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        cyc("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        cyc("abort_nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during the gap; no resumption afterwards.
        pattern = 4'b1011; repeat_cnt = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int bi = 3; bi >= 0; bi--) begin
            cyc("rstgap_bit", 1'b0, pattern[bi], 1'b1, 1'b1, 1'b0);
            step();
        end
        cyc("rstgap_gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc("rstgap_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rstgap_b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            cyc("rstgap_noresume", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // start and abort together in idle: start wins.
        pattern = 4'b1011; repeat_cnt = 4'd1; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        cyc("sa_b3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        cyc("sa_b2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        cyc("sa_b1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        cyc("sa_b0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        cyc("sa_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        cyc("sa_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // abort alone in idle does nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        cyc("abort_in_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter WIDTH, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted between repetitions; legal range 0..15.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 pattern  input  WIDTH  bit pattern to emit, MSB first; latched on accepted start.
REQ-007 repeat_cnt  input  4  number of pattern repetitions; latched on accepted start; 0 treated as 1.
REQ-008 abort  input  1  cancel an in-progress transmission.
REQ-009 out  output  1  serial bit stream for a downstream sequence detector's `in`.
REQ-010 valid  output  1  high when `out` carries a pattern bit.
REQ-011 busy  output  1  high from first emitted bit through last emitted bit, including gaps.
REQ-012 done  output  1  one-cycle pulse after normal completion.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 States SHALL be IDLE, SEND, GAP, DONE.
REQ-015 IDLE: out=0, valid=0, busy=0, done=0.
REQ-016 IDLE with start=1 at edge k: latch pattern and max(repeat_cnt,1); enter SEND; cycle after edge k SHALL show out=pattern[WIDTH-1], valid=1, busy=1.
REQ-017 SEND: one bit per cycle, index WIDTH-1 down to 0; valid=1, busy=1.
REQ-018 After bit 0, repetitions remaining and GAP_CYCLES>0: enter GAP.
REQ-019 After bit 0, repetitions remaining and GAP_CYCLES=0: restart at pattern[WIDTH-1] the next cycle, with no gap cycle between repetitions.
REQ-020 GAP: exactly GAP_CYCLES cycles with out=0, valid=0, busy=1; then SEND from index WIDTH-1.
REQ-021 After bit 0 of the final repetition: enter DONE.
REQ-022 DONE: exactly one cycle with done=1, busy=0, valid=0, out=0; then IDLE.
REQ-023 start in SEND, GAP or DONE SHALL be ignored (no re-latch, no queuing).
REQ-024 A start asserted in the DONE cycle SHALL NOT be accepted; a start is accepted only while in IDLE.
REQ-025 pattern and repeat_cnt changes after the latching edge SHALL NOT affect the transmission in progress.
REQ-026 Total busy cycles SHALL equal R*WIDTH + (R-1)*GAP_CYCLES, where R=max(repeat_cnt,1).
REQ-027 abort=1 in SEND or GAP: next cycle in IDLE with all outputs 0 and no done pulse.
REQ-028 abort has no effect in IDLE or DONE.
REQ-029 abort and start both high in IDLE: start SHALL win.
REQ-030 Bit-index and repetition counters SHALL be sized for WIDTH up to 16 and repeat_cnt up to 15 without wrap.

Reset
REQ-031 rst=1 at any edge SHALL force IDLE: out=0, valid=0, busy=0, done=0, counters cleared, latched pattern cleared.
REQ-032 rst SHALL take priority over start and abort.
REQ-033 Reset mid-transmission SHALL produce no done pulse and SHALL NOT resume after release.

Verification
REQ-034 WIDTH=4, pattern=1011, repeat_cnt=1, one-cycle start -> out 1,0,1,1 with valid=1 for 4 cycles, then done=1 for 1 cycle, busy=1 for exactly 4 cycles.
REQ-035 pattern=1011, repeat_cnt=2, GAP_CYCLES=2 -> out/valid sequence 1011, 00 (valid=0), 1011; busy=1 for 10 cycles; single done pulse.
REQ-036 repeat_cnt=0 -> identical waveform to repeat_cnt=1; repeat_cnt=3, GAP_CYCLES=0 -> 12 contiguous valid bits 101110111011.
REQ-037 start re-pulsed and pattern changed to 0110 during SEND -> stream unchanged (1011), no extra transmission, one done pulse.
REQ-038 abort during bit 2 -> next cycle out=0, valid=0, busy=0, no done; rst during GAP -> same idle response and no resumption after rst falls.
REQ-039 Loopback: out connected to a 1011 sequence detector's `in` -> detector `detect` pulses once per emitted repetition.
